// File: rtl/shared_mem_scheduler.sv
// Round-robin scheduler for the shared global-memory/device port.
// Supports short lock-based holds and bounded device wait states.
module shared_mem_scheduler #(
  parameter int NUM_REQ     = 16,
  parameter int MAX_HOLD    = 4,
  parameter int DEV_TIMEOUT = 64,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] lock,
  input  logic               device_access,
  input  logic               device_ready,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid,
  output logic               dev_timeout
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int WAIT_W = $clog2(DEV_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM  = HOLD_W'(MAX_HOLD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM  = WAIT_W'(DEV_TIMEOUT - 1);
  localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    HOLD     = 2'd2,
    DEV_WAIT = 2'd3
  } state_t;

  state_t              state_r, state_n;
  logic [NUM_REQ-1:0]  grant_oh_r, grant_oh_n;
  logic [ID_W-1:0]     grant_id_r, grant_id_n;
  logic                grant_valid_r, grant_valid_n;
  logic                dev_timeout_r, dev_timeout_n;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_n;
  logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_n;
  logic [ID_W-1:0]     last_id_r, last_id_n;
  logic [ID_W-1:0]     winner_s;
  logic                rearb_s;
  logic                dev_stall_s;
  logic                owner_keep_s;

  // First requester scanning upward from last+1, wrapping at NUM_REQ-1.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last);
    logic            found;
    logic [ID_W-1:0] idx;
    rr_pick = {ID_W{1'b0}};
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found   = found;
      end
    end
  endfunction

  // Next-state, counter and grant computation.
  always_comb begin
    state_n       = state_r;
    grant_id_n    = grant_id_r;
    grant_valid_n = grant_valid_r;
    hold_cnt_n    = hold_cnt_r;
    wait_cnt_n    = wait_cnt_r;
    last_id_n     = last_id_r;
    dev_timeout_n = 1'b0;
    rearb_s       = 1'b0;
    winner_s      = rr_pick(request, last_id_r);
    dev_stall_s   = device_access & ~device_ready;
    owner_keep_s  = lock[grant_id_r] & request[grant_id_r];

    case (state_r)
      IDLE: rearb_s = 1'b1;
      GRANT, HOLD: begin
        // A stalled device access outranks the lock.
        if (dev_stall_s) begin
          if (wait_cnt_r == WAIT_LIM) begin
            rearb_s       = 1'b1;
            dev_timeout_n = 1'b1;
          end else begin
            state_n    = DEV_WAIT;
            wait_cnt_n = wait_cnt_r + WAIT_W'(1);
          end
        end else if (owner_keep_s && (hold_cnt_r < HOLD_LIM)) begin
          state_n    = HOLD;
          hold_cnt_n = hold_cnt_r + HOLD_W'(1);
        end else begin
          rearb_s = 1'b1;
        end
      end
      DEV_WAIT: begin
        if (device_ready) begin
          rearb_s = 1'b1;
        end else if (wait_cnt_r == WAIT_LIM) begin
          rearb_s       = 1'b1;
          dev_timeout_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt_r + WAIT_W'(1);
        end
      end
      default: rearb_s = 1'b1;
    endcase

    if (rearb_s) begin
      hold_cnt_n = {HOLD_W{1'b0}};
      wait_cnt_n = {WAIT_W{1'b0}};
      if (|request) begin
        state_n       = GRANT;
        grant_id_n    = winner_s;
        grant_valid_n = 1'b1;
        last_id_n     = winner_s;
      end else begin
        state_n       = IDLE;
        grant_id_n    = {ID_W{1'b0}};
        grant_valid_n = 1'b0;
      end
    end else begin
      last_id_n = last_id_r;
    end

    grant_oh_n = grant_valid_n ? (NUM_REQ'(1) << grant_id_n) : {NUM_REQ{1'b0}};
  end

  // State and output registers; last_id resets so core 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      grant_oh_r    <= {NUM_REQ{1'b0}};
      grant_id_r    <= {ID_W{1'b0}};
      grant_valid_r <= 1'b0;
      dev_timeout_r <= 1'b0;
      hold_cnt_r    <= {HOLD_W{1'b0}};
      wait_cnt_r    <= {WAIT_W{1'b0}};
      last_id_r     <= LAST_INIT;
    end else begin
      state_r       <= state_n;
      grant_oh_r    <= grant_oh_n;
      grant_id_r    <= grant_id_n;
      grant_valid_r <= grant_valid_n;
      dev_timeout_r <= dev_timeout_n;
      hold_cnt_r    <= hold_cnt_n;
      wait_cnt_r    <= wait_cnt_n;
      last_id_r     <= last_id_n;
    end
  end

  assign grant_oh    = grant_oh_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign dev_timeout = dev_timeout_r;

endmodule

// File: tb/tb_shared_mem_scheduler.sv
// Directed + randomized bench for shared_mem_scheduler against a cycle-level
// reference model of the arbitration rules.
module tb_shared_mem_scheduler;

  localparam int N      = 16;
  localparam int MAX_H  = 4;
  localparam int DEV_TO = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  request;
  logic [N-1:0]  lock;
  logic          device_access;
  logic          device_ready;
  logic [N-1:0]  grant_oh;
  logic [3:0]    grant_id;
  logic          grant_valid;
  logic          dev_timeout;

  int checks = 0;
  int errors = 0;

  // Reference model: granted core (-1 idle), last winner, cycles held,
  // wait cycles seen, whether a device wait is ongoing, expected pulse.
  int m_cur, m_last, m_held, m_waits;
  bit m_inwait, m_to;

  shared_mem_scheduler #(
    .NUM_REQ(N), .MAX_HOLD(MAX_H), .DEV_TIMEOUT(DEV_TO)
  ) dut (
    .clk(clk), .reset(reset), .request(request), .lock(lock),
    .device_access(device_access), .device_ready(device_ready),
    .grant_oh(grant_oh), .grant_id(grant_id), .grant_valid(grant_valid),
    .dev_timeout(dev_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1; m_last = N - 1; m_held = 0; m_waits = 0; m_inwait = 1'b0; m_to = 1'b0;
  endtask

  task automatic model_grant();
    m_inwait = 1'b0;
    m_waits  = 0;
    m_held   = 0;
    if (request == '0) begin
      m_cur = -1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        if (request[(m_last + k) % N]) begin
          m_cur = (m_last + k) % N;
          break;
        end
      end
      m_last = m_cur;
      m_held = 1;
    end
  endtask

  task automatic model_step();
    m_to = 1'b0;
    if (m_cur < 0) begin
      if (request != '0) model_grant();
    end else if (m_inwait) begin
      m_waits++;
      if (device_ready) model_grant();
      else if (m_waits >= DEV_TO) begin m_to = 1'b1; model_grant(); end
    end else if (device_access && !device_ready) begin
      m_waits = 1;
      if (m_waits >= DEV_TO) begin m_to = 1'b1; model_grant(); end
      else m_inwait = 1'b1;
    end else if (lock[m_cur] && request[m_cur] && m_held < MAX_H) begin
      m_held++;
    end else begin
      model_grant();
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] exp_oh;
    exp_oh = (m_cur >= 0) ? (16'd1 << m_cur) : 16'd0;
    chk({tag, "_valid"}, 32'(grant_valid), 32'(m_cur >= 0));
    chk({tag, "_oh"}, 32'(grant_oh), 32'(exp_oh));
    if (m_cur >= 0) chk({tag, "_id"}, 32'(grant_id), 32'(m_cur));
    chk({tag, "_timeout"}, 32'(dev_timeout), 32'(m_to));
    chk({tag, "_onehot"}, 32'($onehot0(grant_oh)), 32'd1);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int pulses;
    reset = 1'b1; request = '0; lock = '0; device_access = 1'b0; device_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset");

    // Requests during reset must not produce a grant.
    request = 16'hFFFF;
    @(posedge clk);
    #1;
    check_model("in_reset");
    reset = 1'b0;
    request = '0;
    cycle("idle");

    // Two requesters alternate, first grant one cycle after request.
    request = 16'h0005;
    for (int k = 0; k < 6; k++) begin
      cycle("alt");
      chk("alt_seq", 32'(grant_id), (k % 2 == 0) ? 32'd0 : 32'd2);
    end

    // All requesting: strict rotation 0..15,0.
    do_reset();
    request = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      cycle("rot");
      chk("rot_seq", 32'(grant_id), 32'(k % 16));
    end

    // Lock holds core 3 for MAX_HOLD cycles, then core 5.
    do_reset();
    request = 16'h0008;
    cycle("lock_first");
    chk("lock_first_id", 32'(grant_id), 32'd3);
    request = 16'h0028; lock = 16'h0008;
    for (int k = 0; k < 3; k++) begin
      cycle("lock_hold");
      chk("lock_hold_id", 32'(grant_id), 32'd3);
    end
    cycle("lock_release");
    chk("lock_next_id", 32'(grant_id), 32'd5);
    lock = '0;

    // Device wait ended by ready after 5 low cycles.
    do_reset();
    request = 16'h0002;
    cycle("dev_first");
    request = 16'h0012; device_access = 1'b1; device_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle("dev_wait");
      chk("dev_wait_id", 32'(grant_id), 32'd1);
    end
    device_ready = 1'b1;
    cycle("dev_ready");
    chk("dev_ready_id", 32'(grant_id), 32'd4);
    chk("dev_ready_to", 32'(dev_timeout), 32'd0);

    // Device never ready: one timeout pulse after 8 wait cycles.
    device_ready = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      cycle("dev_to");
      if (dev_timeout === 1'b1) pulses++;
    end
    chk("dev_to_pulse", 32'(dev_timeout), 32'd1);
    chk("dev_to_moved", 32'(grant_id), 32'd1);
    device_access = 1'b0;
    cycle("dev_to_after");
    chk("dev_to_count", 32'(pulses), 32'd1);

    // Asynchronous reset in the middle of a device wait.
    device_access = 1'b1;
    cycle("pre_areset");
    cycle("pre_areset");
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("areset");
    chk("areset_id", 32'(grant_id), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    device_access = 1'b0;
    request = 16'h000F;
    cycle("post_reset");
    chk("post_reset_id", 32'(grant_id), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      request       = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535));
      lock          = 16'($urandom_range(0, 65535));
      device_access = ($urandom_range(0, 3) == 0);
      device_ready  = ($urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
